// File: rtl/key_input_conditioner.sv
// key_input_conditioner: per-key two-flop synchroniser, debouncer and press/release strobes.
// Optional build macro AUTOREPEAT_EN adds held-key auto-repeat on key_press.
module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_db,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sets that would wrap the debounce counter or reload repeat negatively.
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1) ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
        $error("key_input_conditioner: invalid parameter set");
    end

    logic [NUM_KEYS-1:0] sync_a;
    logic [NUM_KEYS-1:0] sync_b;
    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] repeat_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= keys_in;
            sync_b <= sync_a;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic             differ;

        assign differ    = sync_b[k] ^ keys_db[k];
        assign accept[k] = differ && (cnt == DB_LAST);

        // Any cycle where the synchronised level agrees with the accepted level restarts the count.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (!differ || accept[k]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RCNT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RCNT_W-1:0] R_LAST   = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] R_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_RATE);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rep
        logic [RCNT_W-1:0] rcnt;

        // accept while keys_db is high is a release; it wins over a coincident repeat.
        assign repeat_hit[k] = keys_db[k] && !accept[k] && (rcnt == R_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt <= '0;
            end else if (!keys_db[k] || accept[k]) begin
                rcnt <= '0;
            end else if (rcnt == R_LAST) begin
                rcnt <= R_RELOAD;
            end else begin
                rcnt <= rcnt + RCNT_W'(1);
            end
        end
    end
`else
    assign repeat_hit = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys_db     <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            keys_db     <= keys_db ^ accept;
            key_press   <= (accept & sync_b) | repeat_hit;
            key_release <= accept & ~sync_b;
        end
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench for key_input_conditioner: directed vector table, hand-written
// reset / auto-repeat sequences, then random stimulus against a window-based reference model.
module tb_key_input_conditioner;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] keys_in = '0;
    logic [NK-1:0] keys_db;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_input_conditioner #(
        .NUM_KEYS(NK), .CNT_W(16), .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .keys_in(keys_in),
        .keys_db(keys_db), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NK-1:0] keys;
        logic [NK-1:0] db;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } vec_t;
    vec_t vecs[$];

    // Reference model: a new level is accepted once the synchronised input has
    // disagreed with the accepted level for the last DC edges in a row.
    logic [NK-1:0] raw_q[$];
    logic [NK-1:0] s_q[$];
    logic [NK-1:0] m_db = '0;
    logic [NK-1:0] m_press = '0;
    logic [NK-1:0] m_rel = '0;
    int            acc_edge[NK];
    int            edge_n = 0;

    function automatic void model_edge(input logic rst_ok, input logic [NK-1:0] raw);
        logic [NK-1:0] s_pre;
        logic [NK-1:0] nd;
        logic          acc;
        if (!rst_ok) begin
            raw_q.delete();
            s_q.delete();
            m_db = '0; m_press = '0; m_rel = '0;
            return;
        end
        edge_n++;
        s_pre = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
        raw_q.push_back(raw);
        if (raw_q.size() > 4) void'(raw_q.pop_front());
        s_q.push_back(s_pre);
        if (s_q.size() > DC) void'(s_q.pop_front());
        nd = m_db; m_press = '0; m_rel = '0;
        for (int k = 0; k < NK; k++) begin
            acc = (s_q.size() == DC);
            foreach (s_q[j]) if (s_q[j][k] == m_db[k]) acc = 1'b0;
            if (acc) begin
                nd[k]      = s_pre[k];
                m_press[k] = s_pre[k];
                m_rel[k]   = ~s_pre[k];
                if (s_pre[k]) acc_edge[k] = edge_n;
            end
`ifdef AUTOREPEAT_EN
            else if (m_db[k] && (edge_n - acc_edge[k]) >= RD &&
                     ((edge_n - acc_edge[k] - RD) % RR) == 0) begin
                m_press[k] = 1'b1;
            end
`endif
        end
        m_db = nd;
    endfunction

    task automatic tick(input logic [NK-1:0] k);
        keys_in = k;
        @(posedge clk);
        model_edge(reset, keys_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [NK-1:0] k, input int n,
                                input logic [NK-1:0] db, input logic [NK-1:0] p,
                                input logic [NK-1:0] r);
        vec_t v;
        v.keys = k; v.db = db; v.press = p; v.rel = r;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic logic exp_rep(input int k);
`ifdef AUTOREPEAT_EN
        return (k >= RD) && (((k - RD) % RR) == 0) && (k < 30);
`else
        return (k < 0);
`endif
    endfunction

    initial begin
        logic [NK-1:0] rk;
        int            p;

        // Reset held with all keys pressed.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(4'hF);
            chk("rst_db", keys_db, '0);
            chk("rst_press", key_press, '0);
            chk("rst_rel", key_release, '0);
        end
        reset = 1'b1;

        // Row n is the n-th rising edge after reset release.
        add(4'hF, 5, 4'h0, 4'h0, 4'h0);   // held keys: nothing before edge 6
        add(4'hF, 1, 4'hF, 4'hF, 4'h0);
        add(4'hF, 1, 4'hF, 4'h0, 4'h0);
        add(4'h0, 5, 4'hF, 4'h0, 4'h0);   // release all
        add(4'h0, 1, 4'h0, 4'h0, 4'hF);
        add(4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(4'h2, 1, 4'h0, 4'h0, 4'h0);   // bounce on key 1
        add(4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(4'h2, 1, 4'h0, 4'h0, 4'h0);
        add(4'h0, 7, 4'h0, 4'h0, 4'h0);
        add(4'h1, 5, 4'h0, 4'h0, 4'h0);   // clean press key 0
        add(4'h1, 1, 4'h1, 4'h1, 4'h0);
        add(4'h1, 1, 4'h1, 4'h0, 4'h0);
        add(4'h0, 5, 4'h1, 4'h0, 4'h0);   // release key 0
        add(4'h0, 1, 4'h0, 4'h0, 4'h1);
        add(4'h0, 1, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].keys);
            chk($sformatf("tbl%0d_db", i), keys_db, vecs[i].db);
            chk($sformatf("tbl%0d_press", i), key_press, vecs[i].press);
            chk($sformatf("tbl%0d_rel", i), key_release, vecs[i].rel);
        end

        // Mid-count reset: key 2 mismatching for 3 counted cycles, then a one-cycle reset.
        for (int i = 1; i <= 5; i++) begin
            tick(4'h4);
            chk("midrst_pre_db", keys_db, '0);
        end
        reset = 1'b0;
        #1;
        chk("midrst_async_db", keys_db, '0);
        tick(4'h4);
        chk("midrst_in_db", keys_db, '0);
        chk("midrst_in_press", key_press, '0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(4'h4);
            chk("midrst_post_db", keys_db, '0);
            chk("midrst_post_press", key_press, '0);
        end
        tick(4'h4);
        chk("midrst_acc_db", keys_db, 4'h4);
        chk("midrst_acc_press", key_press, 4'h4);
        tick(4'h4);
        chk("midrst_strobe_end", key_press, '0);

        // Key 3 held; acceptance on the 6th edge, then repeat window and release.
        for (int i = 1; i <= 6; i++) tick(4'hC);
        chk("rep_acc_db3", {3'b0, keys_db[3]}, 4'h1);
        chk("rep_acc_press3", {3'b0, key_press[3]}, 4'h1);
        for (int k = 1; k <= 40; k++) begin
            tick((k <= 24) ? 4'hC : 4'h4);
            chk($sformatf("rep%0d_press3", k), {3'b0, key_press[3]}, {3'b0, exp_rep(k)});
            chk($sformatf("rep%0d_db3", k), {3'b0, keys_db[3]}, {3'b0, (k < 30)});
            chk($sformatf("rep%0d_rel3", k), {3'b0, key_release[3]}, {3'b0, (k == 30)});
        end

        // Random stimulus against the reference model.
        rk = keys_in;
        for (int c = 0; c < 3000; c++) begin
            p = (c < 1500) ? 5 : 18;
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, p - 1) == 0) rk[b] = ~rk[b];
            if (c == 2000) reset = 1'b0;
            tick(rk);
            if (c == 2000) reset = 1'b1;
            chk("rnd_db", keys_db, m_db);
            chk("rnd_press", key_press, m_press);
            chk("rnd_rel", key_release, m_rel);
            chk("rnd_excl", key_press & key_release, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
